// File: rtl/paged_mmu.sv
// Paged MMU: 68k function-code aware translation with a small fully associative TLB (optional PAGED_MMU_PAGE_FAULT_EN).
// Latency: supervisor/hit -> resp_valid one cycle after accept; miss -> waits on tbl_ack, then one cycle.
// Backpressure: requester holds req_valid until resp_valid; table fetch stalls while tbl_ack is low.
module paged_mmu #(
    parameter int TASK_W    = 4,
    parameter int VPN_W     = 12,
    parameter int PPN_W     = 16,
    parameter int TLB_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    input  logic [VPN_W-1:0]        vpn,
    input  logic [2:0]              fc,
    input  logic [TASK_W-1:0]       user_map,
    input  logic [7:0]              supervisor_map_1,
    input  logic [7:0]              supervisor_map_2,
    input  logic                    flush,
    output logic                    tbl_rd,
    output logic [TASK_W+VPN_W-1:0] tbl_addr,
    input  logic                    tbl_ack,
    input  logic [PPN_W-1:0]        tbl_data,
    output logic                    resp_valid,
    output logic [PPN_W-1:0]        ppn,
    output logic                    fault
);
    localparam int TAG_W = TASK_W + VPN_W;
    localparam int PTR_W = $clog2(TLB_DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, RESP} state_t;

    state_t                state, state_nxt;
    logic [TAG_W-1:0]      tlb_tag [TLB_DEPTH];
    logic [PPN_W-1:0]      tlb_ppn [TLB_DEPTH];
    logic [TLB_DEPTH-1:0]  tlb_vld;
    logic [PTR_W-1:0]      victim;

    logic                  is_sup;
    logic                  hit;
    logic [PPN_W-1:0]      hit_ppn;
    logic [PPN_W-1:0]      sup_ppn;
    logic                  sup_fault;
    logic                  fill_go;
    logic                  fill_fault;
    logic                  unused_fc;

    assign is_sup    = fc[2];
    assign unused_fc = ^fc[1:0];
    assign tbl_addr  = {user_map, vpn};
    assign fill_go   = (state == FETCH) && tbl_ack;

`ifdef PAGED_MMU_PAGE_FAULT_EN
    assign fill_fault = (tbl_data == '0);
`else
    assign fill_fault = 1'b0;
`endif

    // Fixed supervisor windows: two 1K direct regions, two 256-page relocatable windows.
    always_comb begin
        sup_ppn   = '0;
        sup_fault = 1'b0;
        case (vpn[11:8])
            4'h0, 4'h1, 4'h2, 4'h3: sup_ppn = PPN_W'({6'b100000, vpn[9:0]});
            4'h4, 4'h5, 4'h6, 4'h7: sup_ppn = PPN_W'({6'b010000, vpn[9:0]});
            4'h8:                   sup_ppn = PPN_W'({supervisor_map_1, vpn[7:0]});
            4'h9:                   sup_ppn = PPN_W'({supervisor_map_2, vpn[7:0]});
            default:                sup_fault = 1'b1;
        endcase
    end

    always_comb begin
        hit     = 1'b0;
        hit_ppn = '0;
        for (int i = 0; i < TLB_DEPTH; i++) begin
            if (tlb_vld[i] && (tlb_tag[i] == tbl_addr)) begin
                hit     = 1'b1;
                hit_ppn = tlb_ppn[i];
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        tbl_rd     = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) state_nxt = (is_sup || hit) ? RESP : FETCH;
            end
            FETCH: begin
                tbl_rd = 1'b1;
                if (tbl_ack) state_nxt = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            tlb_vld <= '0;
            victim  <= '0;
            ppn     <= '0;
            fault   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && req_valid) begin
                if (is_sup) begin
                    ppn   <= sup_ppn;
                    fault <= sup_fault;
                end else if (hit) begin
                    ppn   <= hit_ppn;
                    fault <= 1'b0;
                end
            end
            if (fill_go) begin
                ppn   <= fill_fault ? '0 : tbl_data;
                fault <= fill_fault;
                if (!fill_fault) begin
                    tlb_vld[victim] <= 1'b1;
                    victim          <= victim + 1'b1;
                end
            end
            // Flush is last so it overrides a coincident fill's valid bit.
            if (flush) tlb_vld <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && fill_go && !fill_fault) begin
            tlb_tag[victim] <= tbl_addr;
            tlb_ppn[victim] <= tbl_data;
        end
    end

endmodule

// File: tb/tb_paged_mmu.sv
// Bench for paged_mmu: directed scenarios plus randomized traffic against a behavioural TLB/page-table model.
module tb_paged_mmu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [11:0] vpn = '0;
    logic [2:0]  fc = '0;
    logic [3:0]  user_map = '0;
    logic [7:0]  supervisor_map_1 = '0;
    logic [7:0]  supervisor_map_2 = '0;
    logic        flush = 1'b0;
    logic        tbl_rd;
    logic [15:0] tbl_addr;
    logic        tbl_ack = 1'b0;
    logic [15:0] tbl_data = '0;
    logic        resp_valid;
    logic [15:0] ppn;
    logic        fault;

    paged_mmu dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .vpn(vpn), .fc(fc),
        .user_map(user_map), .supervisor_map_1(supervisor_map_1),
        .supervisor_map_2(supervisor_map_2), .flush(flush), .tbl_rd(tbl_rd),
        .tbl_addr(tbl_addr), .tbl_ack(tbl_ack), .tbl_data(tbl_data),
        .resp_valid(resp_valid), .ppn(ppn), .fault(fault)
    );

    always #5 clk = ~clk;

`ifdef PAGED_MMU_PAGE_FAULT_EN
    localparam bit FAULT_EN = 1'b1;
`else
    localparam bit FAULT_EN = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] ppn;
        logic        fault;
    } exp_t;

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t scb[$];

    // Reference state: page-table contents and TLB slots filled round-robin.
    logic [15:0] pt [logic [15:0]];
    logic [15:0] m_tag [4];
    bit          m_val [4];
    int          m_ptr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] pt_get(input logic [15:0] tag);
        if (!pt.exists(tag)) pt[tag] = 16'($urandom_range(1, 16'hFFFF));
        return pt[tag];
    endfunction

    function automatic exp_t sup_model(input logic [11:0] v, input logic [7:0] m1, input logic [7:0] m2);
        exp_t e;
        e.fault = 1'b0;
        if (v < 12'h400)      e.ppn = 16'h8000 + 16'(v);
        else if (v < 12'h800) e.ppn = 16'h4000 + 16'(v - 12'h400);
        else if (v < 12'h900) e.ppn = 16'(m1) * 16'd256 + 16'(v - 12'h800);
        else if (v < 12'hA00) e.ppn = 16'(m2) * 16'd256 + 16'(v - 12'h900);
        else begin
            e.ppn   = 16'h0;
            e.fault = 1'b1;
        end
        return e;
    endfunction

    function automatic int model_find(input logic [15:0] tag);
        for (int i = 0; i < 4; i++) if (m_val[i] && m_tag[i] == tag) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_val[i] = 1'b0;
        m_ptr = 0;
    endtask

    // Called right after a negedge with the DUT idle; returns after the DUT is idle again.
    task automatic do_req(input bit sup, input logic [3:0] tk, input logic [11:0] v,
                          input logic [7:0] m1, input logic [7:0] m2, input int waits, input bit fl);
        exp_t        e;
        bit          miss;
        bit          zf;
        bit          done;
        int          slot;
        int          lat;
        int          n_rd;
        logic [15:0] tag;
        logic [15:0] d;
        tag  = {tk, v};
        miss = 1'b0;
        zf   = 1'b0;
        d    = '0;
        if (sup) begin
            e = sup_model(v, m1, m2);
        end else begin
            slot = model_find(tag);
            if (slot >= 0) begin
                e.ppn   = pt[tag];
                e.fault = 1'b0;
            end else begin
                miss    = 1'b1;
                d       = pt_get(tag);
                zf      = FAULT_EN && (d == 16'h0);
                e.ppn   = zf ? 16'h0 : d;
                e.fault = zf;
            end
        end
        scb.push_back(e);

        req_valid        = 1'b1;
        fc               = sup ? 3'b101 : 3'b001;
        user_map         = tk;
        vpn              = v;
        supervisor_map_1 = m1;
        supervisor_map_2 = m2;
        lat  = 0;
        n_rd = 0;
        done = 1'b0;
        while (!done && lat < 64) begin
            @(negedge clk);
            lat++;
            if (resp_valid) begin
                done      = 1'b1;
                req_valid = 1'b0;
                tbl_ack   = 1'b0;
                flush     = 1'b0;
            end else if (tbl_rd) begin
                n_rd++;
                if (n_rd == 1) check("tbl_addr", 32'(tbl_addr), 32'(tag));
                if (n_rd > waits) begin
                    tbl_ack  = 1'b1;
                    tbl_data = d;
                    flush    = fl;
                end
            end
        end
        if (!done) begin
            check("resp_timeout", 32'(lat), 32'd0);
            req_valid = 1'b0;
            tbl_ack   = 1'b0;
            flush     = 1'b0;
        end
        check("tbl_rd_cycles", 32'(n_rd), miss ? 32'(waits + 1) : 32'd0);
        check("latency", 32'(lat), miss ? 32'(waits + 2) : 32'd1);

        if (miss) begin
            if (!zf) begin
                m_tag[m_ptr] = tag;
                m_val[m_ptr] = 1'b1;
                m_ptr        = (m_ptr + 1) % 4;
            end
            if (fl) for (int i = 0; i < 4; i++) m_val[i] = 1'b0;
        end
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && resp_valid) begin
            if (scb.size() == 0) begin
                check("unexpected_resp", 32'(resp_valid), 32'd0);
            end else begin
                e = scb.pop_front();
                check("ppn", 32'(ppn), 32'(e.ppn));
                check("fault", 32'(fault), 32'(e.fault));
            end
        end
    end

    initial begin
        bit          sup;
        logic [3:0]  tk;
        logic [11:0] v;
        model_reset();

        repeat (3) @(negedge clk);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_tbl_rd", 32'(tbl_rd), 32'd0);
        check("rst_ppn", 32'(ppn), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Supervisor windows
        do_req(1, 4'h0, 12'h3FF, 8'h12, 8'h34, 0, 0);
        do_req(1, 4'h0, 12'h401, 8'h12, 8'h34, 0, 0);
        do_req(1, 4'h0, 12'h8AB, 8'h12, 8'h34, 0, 0);
        do_req(1, 4'h0, 12'h9CD, 8'h12, 8'h34, 0, 0);
        do_req(1, 4'h0, 12'hA00, 8'h12, 8'h34, 0, 0);
        do_req(1, 4'h0, 12'hFFF, 8'h12, 8'h34, 0, 0);

        // Miss with wait states, then hit
        pt[16'h1002] = 16'h1234;
        do_req(0, 4'h1, 12'h002, 8'h0, 8'h0, 3, 0);
        do_req(0, 4'h1, 12'h002, 8'h0, 8'h0, 0, 0);

        // Round-robin eviction: 5 pages through 4 slots
        model_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) do_req(0, 4'h3, 12'h010 + 12'(i), 8'h0, 8'h0, 1, 0);
        for (int i = 1; i < 5; i++) do_req(0, 4'h3, 12'h010 + 12'(i), 8'h0, 8'h0, 0, 0);
        do_req(0, 4'h3, 12'h010, 8'h0, 8'h0, 2, 0);

        // Flush coincident with fill, and task-tagged entries
        do_req(0, 4'h1, 12'h020, 8'h0, 8'h0, 0, 1);
        do_req(0, 4'h1, 12'h020, 8'h0, 8'h0, 0, 0);
        do_req(0, 4'h2, 12'h020, 8'h0, 8'h0, 1, 0);
        do_req(0, 4'h1, 12'h020, 8'h0, 8'h0, 0, 0);

        // Zero table entry
        pt[16'h4055] = 16'h0000;
        do_req(0, 4'h4, 12'h055, 8'h0, 8'h0, 0, 0);
        do_req(0, 4'h4, 12'h055, 8'h0, 8'h0, 0, 0);

        // Randomized traffic
        for (int n = 0; n < 200; n++) begin
            sup = ($urandom_range(0, 3) == 0);
            tk  = 4'($urandom_range(0, 3));
            v   = sup ? 12'($urandom) : 12'($urandom_range(0, 7));
            do_req(sup, tk, v, 8'($urandom), 8'($urandom), $urandom_range(0, 3),
                   ($urandom_range(0, 15) == 0));
        end

        // Reset during FETCH with a coincident tbl_ack
        do_req(1, 4'h0, 12'h3FF, 8'h0, 8'h0, 0, 0);
        req_valid = 1'b1;
        fc        = 3'b001;
        user_map  = 4'h5;
        vpn       = 12'h077;
        @(negedge clk);
        check("midrst_fetch", 32'(tbl_rd), 32'd1);
        tbl_ack  = 1'b1;
        tbl_data = 16'h5555;
        rst      = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        tbl_ack   = 1'b0;
        check("midrst_resp_valid", 32'(resp_valid), 32'd0);
        check("midrst_tbl_rd", 32'(tbl_rd), 32'd0);
        check("midrst_ppn", 32'(ppn), 32'd0);
        check("midrst_fault", 32'(fault), 32'd0);
        rst = 1'b0;
        model_reset();
        repeat (3) begin
            @(negedge clk);
            check("midrst_idle", 32'(resp_valid), 32'd0);
        end
        pt[16'h5077] = 16'h5555;
        do_req(0, 4'h5, 12'h077, 8'h0, 8'h0, 0, 0);

        repeat (2) @(negedge clk);
        check("scoreboard_empty", 32'(scb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/paged_mmu.md
PAGED_MMU -- requirements
Module: paged_mmu

Interface
REQ-001 Parameter TASK_W, default 4, user task-number width; user_map width and upper page-table address bits.
REQ-002 Parameter VPN_W, default 12, virtual page-number width (address bits 23:12).
REQ-003 Parameter PPN_W, default 16, physical page-number width (address bits 27:12) and table-entry width.
REQ-004 Parameter TLB_DEPTH, default 4, number of cached translations; power of two, range 2..16.
REQ-005 Port clk, input, 1, single clock; all state changes on its rising edge.
REQ-006 Port rst, input, 1, synchronous, active-high reset.
REQ-007 Port req_valid, input, 1, translation request; held until resp_valid.
REQ-008 Port vpn, input, VPN_W, virtual page number; stable while req_valid is high.
REQ-009 Port fc, input, 3, 68k function code; fc[2]=1 selects supervisor.
REQ-010 Port user_map, input, TASK_W, current user task.
REQ-011 Port supervisor_map_1, input, 8, page-window-1 base.
REQ-012 Port supervisor_map_2, input, 8, page-window-2 base.
REQ-013 Port flush, input, 1, invalidates all TLB entries.
REQ-014 Port tbl_rd, output, 1, page-table RAM read strobe.
REQ-015 Port tbl_addr, output, TASK_W+VPN_W, page-table RAM address, {user_map, vpn}.
REQ-016 Port tbl_ack, input, 1, table data valid this cycle.
REQ-017 Port tbl_data, input, PPN_W, table entry (physical page number).
REQ-018 Port resp_valid, output, 1, one-cycle response pulse.
REQ-019 Port ppn, output, PPN_W, translated physical page; valid while resp_valid is high.
REQ-020 Port fault, output, 1, translation fault; valid while resp_valid is high.

Function
REQ-021 FSM states SHALL be IDLE, FETCH and RESP; RESP SHALL always return to IDLE after one cycle.
REQ-022 In IDLE with req_valid high, the block SHALL go to RESP when the request is supervisor or a TLB hit, and to FETCH otherwise.
REQ-023 Supervisor mapping: vpn 0x000-0x3FF SHALL give ppn 0x8000|vpn[9:0]; 0x400-0x7FF SHALL give 0x4000|vpn[9:0]; 0x800-0x8FF SHALL give {supervisor_map_1, vpn[7:0]}; 0x900-0x9FF SHALL give {supervisor_map_2, vpn[7:0]}; 0xA00-0xFFF SHALL give ppn 0 with fault=1.
REQ-024 Supervisor requests SHALL NOT read or modify the TLB and SHALL NOT assert tbl_rd.
REQ-025 TLB SHALL be fully associative with tag {user_map, vpn} and a valid bit; a hit requires a tag match on a valid entry.
REQ-026 Hit or supervisor latency: resp_valid SHALL be high in the cycle after the accepting edge.
REQ-027 In FETCH, tbl_rd SHALL be high with tbl_addr={user_map, vpn}, for as many cycles as tbl_ack stays low.
REQ-028 When tbl_ack is sampled high, ppn SHALL take tbl_data, the entry SHALL be written at the round-robin victim pointer, the pointer SHALL advance modulo TLB_DEPTH, and the FSM SHALL go to RESP.
REQ-029 req_valid SHALL be ignored while in RESP; the requester deasserts it or presents the next request in the following cycle.
REQ-030 flush SHALL clear all valid bits at the next edge in any state; a flush in the same cycle as a fill SHALL win, leaving that entry invalid while the response is still delivered.
REQ-031 tag changes from user_map SHALL need no flush; entries of different tasks SHALL coexist.

Reset
REQ-032 At rst, the block SHALL enter IDLE, clear all TLB valid bits, zero the victim pointer, and drive resp_valid=0, fault=0, tbl_rd=0 and ppn=0; a reset during FETCH SHALL abandon the fetch and discard a coincident tbl_ack.

Configuration
REQ-033 With macro PAGED_MMU_PAGE_FAULT_EN defined, a table entry of 0 SHALL return fault=1 and ppn=0 and SHALL NOT be cached; without the macro, entry 0 SHALL be a normal translation to page 0, cached, with fault=0 for all user translations.

Verification
REQ-034 Supervisor vpn 0x3FF -> resp_valid the next cycle, ppn 0x83FF; vpn 0x401 -> ppn 0x4001; vpn 0x8AB with supervisor_map_1=0x12 -> ppn 0x12AB; no tbl_rd.
REQ-035 User miss: user_map=1, vpn 0x002, tbl_ack after 3 wait cycles with tbl_data 0x1234 -> tbl_addr 0x1002, then ppn 0x1234; repeat the request -> hit with 1-cycle latency and no tbl_rd.
REQ-036 Fill 5 distinct pages with TLB_DEPTH=4 -> the first page misses again and the others hit.
REQ-037 flush asserted in the fill cycle -> response delivered, then the same request misses; user_map=2 with the same vpn -> miss.
REQ-038 tbl_data 0 with PAGED_MMU_PAGE_FAULT_EN -> fault=1 and the repeat request misses; without the macro -> fault=0, ppn 0, and the repeat request hits.
REQ-039 rst asserted mid-FETCH with tbl_ack high -> IDLE, no resp_valid, and all outputs zero.
